// File: rtl/rtc_irq_ctrl_if.sv
// CPU-side soft-switch bus for the interrupt status/enable block.
// One access is taken on the first cen cycle of each strobe assertion. The access happens at the
// clock edge where strobe & cen are high and strobe was low on the previous cen cycle. dout holds
// the read data from the clock cycle after that edge.
interface rtc_irq_ctrl_if;
  logic       cen;
  logic [7:0] addr;
  logic [7:0] din;
  logic       rw;
  logic       strobe;
  logic [7:0] dout;

  modport master (
    output cen,
    output addr,
    output din,
    output rw,
    output strobe,
    input  dout
  );

  modport slave (
    input  cen,
    input  addr,
    input  din,
    input  rw,
    input  strobe,
    output dout
  );
endinterface

// File: rtl/rtc_irq_ctrl.sv
// IIgs interrupt status/enable registers ($C023/$C032/$C041/$C046/$C047) latching clock-chip
// ticks and VGC scanline/VBL pulses into status bits, with a level irq and overrun counters.
module rtc_irq_ctrl #(
  parameter int SAT_MAX = 7
) (
  input  logic             CLK_14M,
  input  logic             reset_n,
  rtc_irq_ctrl_if.slave    bus,
  input  logic             onesecond_irq,
  input  logic             qtrsecond_irq,
  input  logic             scanline_irq,
  input  logic             vbl_irq,
  output logic             irq,
  output logic [2:0]       sec_overrun,
  output logic [2:0]       qtr_overrun
);

  localparam logic [2:0] OV_SAT = 3'(SAT_MAX);

  localparam logic [7:0] ADDR_VGCINT  = 8'h23;
  localparam logic [7:0] ADDR_VGCCLR  = 8'h32;
  localparam logic [7:0] ADDR_INTEN   = 8'h41;
  localparam logic [7:0] ADDR_INTFLAG = 8'h46;
  localparam logic [7:0] ADDR_INTCLR  = 8'h47;

  logic       r_strobe_q;
  logic       r_en_sec;
  logic       r_en_scan;
  logic [4:0] r_inten;
  logic       r_sts_sec;
  logic       r_sts_scan;
  logic       r_sts_qtr;
  logic       r_sts_vbl;
  logic [2:0] r_sec_ov;
  logic [2:0] r_qtr_ov;
  logic [7:0] r_dout;
  logic       r_irq;

  logic       w_access;
  logic       w_rd;
  logic       w_wr;
  logic       w_wr_vgcint;
  logic       w_wr_vgcclr;
  logic       w_wr_inten;
  logic       w_wr_intclr;
  logic       w_en_qtr;
  logic       w_en_vbl;
  logic       w_set_sec;
  logic       w_set_scan;
  logic       w_set_qtr;
  logic       w_set_vbl;
  logic       w_clr_sec;
  logic       w_clr_scan;
  logic       w_clr_qv;
  logic       w_irq_vgc;
  logic       w_irq_next;
  logic [7:0] w_rd_data;
  logic       w_unused_din;

  // Edge detect is tracked in the cen domain, so a strobe held across many cen cycles gives one access.
  assign w_access = bus.strobe & bus.cen & ~r_strobe_q;
  assign w_rd     = w_access &  bus.rw;
  assign w_wr     = w_access & ~bus.rw;

  assign w_wr_vgcint = w_wr & (bus.addr == ADDR_VGCINT);
  assign w_wr_vgcclr = w_wr & (bus.addr == ADDR_VGCCLR);
  assign w_wr_inten  = w_wr & (bus.addr == ADDR_INTEN);
  assign w_wr_intclr = w_wr & (bus.addr == ADDR_INTCLR);

  assign w_en_qtr = r_inten[4];
  assign w_en_vbl = r_inten[3];

  assign w_set_sec  = onesecond_irq & r_en_sec;
  assign w_set_scan = scanline_irq  & r_en_scan;
  assign w_set_qtr  = qtrsecond_irq & w_en_qtr;
  assign w_set_vbl  = vbl_irq       & w_en_vbl;

  // $C032 clears on 0 bits; $C047 clears regardless of data.
  assign w_clr_sec  = w_wr_vgcclr & ~bus.din[6];
  assign w_clr_scan = w_wr_vgcclr & ~bus.din[5];
  assign w_clr_qv   = w_wr_intclr;

  assign w_irq_vgc  = (r_sts_sec & r_en_sec) | (r_sts_scan & r_en_scan);
  assign w_irq_next = w_irq_vgc | (r_sts_qtr & w_en_qtr) | (r_sts_vbl & w_en_vbl);

  assign w_unused_din = &{1'b0, bus.din[7], bus.din[3], bus.din[0]};

  // A software clear zeroes the counter even when a set pulse arrives in the same cycle.
  function automatic logic [2:0] ov_next(input logic [2:0] cur, input logic set,
                                         input logic sts, input logic clr);
    logic [2:0] nxt;
    nxt = cur;
    if (clr)
      nxt = 3'd0;
    else if (set && sts && (cur != OV_SAT))
      nxt = cur + 3'd1;
    return nxt;
  endfunction

  always_comb begin
    w_rd_data = r_dout;
    case (bus.addr)
      ADDR_VGCINT:  w_rd_data = {w_irq_vgc, r_sts_sec, r_sts_scan, 2'b00, r_en_sec, r_en_scan, 1'b0};
      ADDR_VGCCLR:  w_rd_data = 8'h00;
      ADDR_INTEN:   w_rd_data = {3'b000, r_inten};
      ADDR_INTFLAG: w_rd_data = {3'b000, r_sts_qtr, r_sts_vbl, 3'b000};
      ADDR_INTCLR:  w_rd_data = 8'h00;
      default:      w_rd_data = r_dout;
    endcase
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_q <= 1'b0;
    end else if (bus.cen) begin
      r_strobe_q <= bus.strobe;
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_en_sec  <= 1'b0;
      r_en_scan <= 1'b0;
      r_inten   <= 5'd0;
    end else begin
      if (w_wr_vgcint) begin
        r_en_sec  <= bus.din[2];
        r_en_scan <= bus.din[1];
      end
      if (w_wr_inten)
        r_inten <= bus.din[4:0];
    end
  end

  // Enable writes never touch status; irq masks by enable instead.
  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_sts_sec  <= 1'b0;
      r_sts_scan <= 1'b0;
      r_sts_qtr  <= 1'b0;
      r_sts_vbl  <= 1'b0;
      r_sec_ov   <= 3'd0;
      r_qtr_ov   <= 3'd0;
    end else begin
      r_sts_sec  <= w_set_sec  | (r_sts_sec  & ~w_clr_sec);
      r_sts_scan <= w_set_scan | (r_sts_scan & ~w_clr_scan);
      r_sts_qtr  <= w_set_qtr  | (r_sts_qtr  & ~w_clr_qv);
      r_sts_vbl  <= w_set_vbl  | (r_sts_vbl  & ~w_clr_qv);
      r_sec_ov   <= ov_next(r_sec_ov, w_set_sec, r_sts_sec, w_clr_sec);
      r_qtr_ov   <= ov_next(r_qtr_ov, w_set_qtr, r_sts_qtr, w_clr_qv);
    end
  end

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= 8'h00;
      r_irq  <= 1'b0;
    end else begin
      if (w_rd)
        r_dout <= w_rd_data;
      r_irq <= w_irq_next;
    end
  end

  assign bus.dout    = r_dout;
  assign irq         = r_irq;
  assign sec_overrun = r_sec_ov;
  assign qtr_overrun = r_qtr_ov;

endmodule

// File: tb/tb_rtc_irq_ctrl.sv
// Randomized scoreboard bench for rtc_irq_ctrl against a register-level reference model.
module tb_rtc_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ev_sec, ev_qtr, ev_scan, ev_vbl;
  logic       irq;
  logic [2:0] sec_overrun, qtr_overrun;

  rtc_irq_ctrl_if bus_if();

  rtc_irq_ctrl #(.SAT_MAX(7)) dut (
    .CLK_14M       (clk),
    .reset_n       (reset_n),
    .bus           (bus_if),
    .onesecond_irq (ev_sec),
    .qtrsecond_irq (ev_qtr),
    .scanline_irq  (ev_scan),
    .vbl_irq       (ev_vbl),
    .irq           (irq),
    .sec_overrun   (sec_overrun),
    .qtr_overrun   (qtr_overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // reference model: the software-visible register state
  logic       m_en_sec, m_en_scan;
  logic [4:0] m_inten;
  logic       m_sts_sec, m_sts_scan, m_sts_qtr, m_sts_vbl;
  int         m_ov_sec, m_ov_qtr;
  logic [7:0] m_dout;

  task automatic model_reset();
    m_en_sec = 0; m_en_scan = 0; m_inten = '0;
    m_sts_sec = 0; m_sts_scan = 0; m_sts_qtr = 0; m_sts_vbl = 0;
    m_ov_sec = 0; m_ov_qtr = 0; m_dout = '0;
  endtask

  function automatic logic m_vgc();
    return (m_sts_sec && m_en_sec) || (m_sts_scan && m_en_scan);
  endfunction

  function automatic logic m_irq();
    return m_vgc() || (m_sts_qtr && m_inten[4]) || (m_sts_vbl && m_inten[3]);
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = m_dout;
    if (a == 8'h23) v = {m_vgc(), m_sts_sec, m_sts_scan, 2'b00, m_en_sec, m_en_scan, 1'b0};
    if (a == 8'h32 || a == 8'h47) v = 8'h00;
    if (a == 8'h41) v = {3'b000, m_inten};
    if (a == 8'h46) v = {3'b000, m_sts_qtr, m_sts_vbl, 3'b000};
    return v;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h23) begin m_en_sec = d[2]; m_en_scan = d[1]; end
    if (a == 8'h32) begin
      if (!d[6]) begin m_sts_sec = 0; m_ov_sec = 0; end
      if (!d[5]) m_sts_scan = 0;
    end
    if (a == 8'h41) m_inten = d[4:0];
    if (a == 8'h47) begin m_sts_qtr = 0; m_sts_vbl = 0; m_ov_qtr = 0; end
  endtask

  // events see the enables as they were before any same-cycle write; sets beat clears
  task automatic model_events(input logic [3:0] ev, input logic o_sec, input logic o_scan,
                              input logic o_qtr, input logic o_vbl);
    if (ev[3] && o_sec) begin
      if (m_sts_sec) m_ov_sec = (m_ov_sec < 7) ? m_ov_sec + 1 : 7;
      m_sts_sec = 1;
    end
    if (ev[2] && o_qtr) begin
      if (m_sts_qtr) m_ov_qtr = (m_ov_qtr < 7) ? m_ov_qtr + 1 : 7;
      m_sts_qtr = 1;
    end
    if (ev[1] && o_scan) m_sts_scan = 1;
    if (ev[0] && o_vbl)  m_sts_vbl  = 1;
  endtask

  // scoreboard
  logic [7:0] exp_q[$];
  string      exp_name_q[$];
  logic [6:0] lvl_q[$];
  string      lvl_name_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       rd_req = 0, rd_req_d = 0;
  logic       lvl_req = 0, lvl_req_d = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    rd_req_d  <= rd_req;
    lvl_req_d <= lvl_req;
  end

  // monitor: compares whenever a read result or level snapshot is presented
  always @(negedge clk) begin
    if (rd_req_d) begin
      if (exp_q.size() == 0) check("rd_underflow", 16'd1, 16'd0);
      else check(exp_name_q.pop_front(), {8'h00, bus_if.dout}, {8'h00, exp_q.pop_front()});
    end
    if (lvl_req_d) begin
      if (lvl_q.size() == 0) check("lvl_underflow", 16'd1, 16'd0);
      else check(lvl_name_q.pop_front(), {9'd0, irq, sec_overrun, qtr_overrun},
                 {9'd0, lvl_q.pop_front()});
    end
  end

  // drivers
  task automatic set_ev(input logic [3:0] ev);
    {ev_sec, ev_qtr, ev_scan, ev_vbl} = ev;
  endtask

  task automatic access(input logic [7:0] a, input logic [7:0] d, input logic rd,
                        input int hold, input logic [3:0] ev, input string name);
    logic o_sec, o_scan, o_qtr, o_vbl;
    @(negedge clk);
    o_sec = m_en_sec; o_scan = m_en_scan; o_qtr = m_inten[4]; o_vbl = m_inten[3];
    if (rd) begin
      m_dout = model_read(a);
      exp_q.push_back(m_dout);
      exp_name_q.push_back(name);
      rd_req = 1;
    end else begin
      model_write(a, d);
    end
    model_events(ev, o_sec, o_scan, o_qtr, o_vbl);
    bus_if.addr = a; bus_if.din = d; bus_if.rw = rd;
    bus_if.strobe = 1; bus_if.cen = 1;
    set_ev(ev);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      rd_req = 0; set_ev(4'b0);
      bus_if.cen = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rd_req = 0; set_ev(4'b0);
    bus_if.strobe = 0; bus_if.cen = 1;
    @(negedge clk);
    bus_if.cen = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    access(a, d, 1'b0, 1, 4'b0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input string name);
    access(a, 8'h00, 1'b1, 1, 4'b0, name);
  endtask

  task automatic pulse(input logic [3:0] ev);
    @(negedge clk);
    model_events(ev, m_en_sec, m_en_scan, m_inten[4], m_inten[3]);
    set_ev(ev);
    @(negedge clk);
    set_ev(4'b0);
  endtask

  task automatic chk_lvl(input string name);
    @(negedge clk);
    @(negedge clk);
    lvl_q.push_back({m_irq(), 3'(m_ov_sec), 3'(m_ov_qtr)});
    lvl_name_q.push_back(name);
    lvl_req = 1;
    @(negedge clk);
    lvl_req = 0;
  endtask

  // stimulus
  initial begin
    logic [7:0] a;
    int op;
    bus_if.cen = 0; bus_if.addr = 0; bus_if.din = 0; bus_if.rw = 1; bus_if.strobe = 0;
    set_ev(4'b0);
    model_reset();
    reset_n = 0;
    #1;
    check("reset_dout", {8'h00, bus_if.dout}, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1;
    chk_lvl("reset_levels");

    // one-second tick and its clear
    wr(8'h23, 8'h04);
    pulse(4'b1000);
    rd(8'h23, "t1_c023_set");
    chk_lvl("t1_irq_set");
    wr(8'h32, 8'hBF);
    rd(8'h23, "t1_c023_clr");
    chk_lvl("t1_irq_clr");

    // disabled events are dropped
    wr(8'h23, 8'h00);
    wr(8'h41, 8'h00);
    pulse(4'b1111);
    pulse(4'b1111);
    rd(8'h23, "t2_c023");
    rd(8'h46, "t2_c046");
    chk_lvl("t2_levels");

    // quarter-second overrun and clear
    wr(8'h41, 8'h10);
    repeat (3) pulse(4'b0100);
    rd(8'h46, "t3_c046_set");
    chk_lvl("t3_qtr_ov");
    wr(8'h47, 8'h5A);
    rd(8'h46, "t3_c046_clr");
    chk_lvl("t3_qtr_ov_clr");

    // long strobe on $C032 with a scanline pulse on the first cen
    wr(8'h23, 8'h06);
    pulse(4'b1010);
    access(8'h32, 8'h00, 1'b0, 5, 4'b0010, "t4_wr");
    rd(8'h23, "t4_c023");
    chk_lvl("t4_levels");

    // enable cleared, status kept
    wr(8'h32, 8'h00);
    wr(8'h23, 8'h04);
    pulse(4'b1000);
    wr(8'h23, 8'h00);
    chk_lvl("t5_irq");
    rd(8'h23, "t5_c023");

    // overrun saturation
    wr(8'h23, 8'h04);
    repeat (10) pulse(4'b1000);
    chk_lvl("sat_sec_ov");
    rd(8'h99, "other_addr_keeps_dout");

    // async reset during a pending access
    wr(8'h41, 8'h08);
    pulse(4'b0001);
    chk_lvl("t6_pre_irq");
    @(negedge clk);
    bus_if.addr = 8'h23; bus_if.rw = 1; bus_if.strobe = 1; bus_if.cen = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    check("t6_async_irq", {15'd0, irq}, 16'h0000);
    check("t6_async_dout", {8'h00, bus_if.dout}, 16'h0000);
    check("t6_async_ov", {10'd0, sec_overrun, qtr_overrun}, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1;
    bus_if.addr = 8'h41; bus_if.cen = 1;
    exp_q.push_back(8'h00); exp_name_q.push_back("t6_strobe_at_release");
    rd_req = 1;
    @(negedge clk);
    rd_req = 0; bus_if.strobe = 0;
    @(negedge clk);
    bus_if.cen = 0;
    rd(8'h23, "t6_c023");
    rd(8'h46, "t6_c046");
    chk_lvl("t6_levels");

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1, 2, 3: begin
          a = (op == 0) ? 8'h23 : (op == 1) ? 8'h32 : (op == 2) ? 8'h41 : 8'h47;
          access(a, 8'($urandom_range(0, 255)), 1'b0, $urandom_range(1, 4),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0, "rnd_wr");
        end
        4: begin
          case ($urandom_range(0, 5))
            0: a = 8'h23;
            1: a = 8'h32;
            2: a = 8'h41;
            3: a = 8'h46;
            4: a = 8'h47;
            default: a = 8'($urandom_range(0, 255));
          endcase
          access(a, 8'h00, 1'b1, $urandom_range(1, 4),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0, "rnd_rd");
        end
        5, 6: pulse(4'($urandom_range(1, 15)));
        default: chk_lvl("rnd_levels");
      endcase
    end
    chk_lvl("final_levels");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size() + lvl_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
